// File: rtl/spi_slave_bridge_pkg.sv
// Shared definitions for the SPI slave bridge: FSM encoding, command codes and widths.
package spi_pkg;

    localparam int RX_W   = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        WAIT_TX   = 3'd5,
        SEND      = 3'd6,
        DONE      = 3'd7
    } spi_state_e;

endpackage

// File: rtl/spi_slave_bridge_tx_serializer.sv
// Loads a byte and shifts it out MSB-first, one bit per clk. o_done is high during
// the last bit cycle so the owner can leave its send state on the same edge.
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_byte,
    output logic              o_miso,
    output logic              o_done
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] r_sh;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_miso;

    assign o_miso = r_miso;
    assign o_done = r_busy && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (i_load) begin
            // MSB goes out immediately; the remaining bits wait in r_sh
            r_sh   <= {i_byte[DATA_W-2:0], 1'b0};
            r_miso <= i_byte[DATA_W-1];
            r_cnt  <= CW'(DATA_W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sh <= {r_sh[DATA_W-2:0], 1'b0};
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                r_miso <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - 1'b1;
                r_miso <= r_sh[DATA_W-1];
            end
        end
    end

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI slave front-end: MOSI frames -> {cmd,payload} rx_data/rx_valid, read bytes -> MISO.
// Define SPI_CMD_CHECK_EN to reject frames whose command bits disagree with the mode/state.
module spi_slave_bridge #(
    parameter int DATA_W      = spi_pkg::DATA_W,
    parameter int RX_W        = spi_pkg::RX_W,
    parameter int TX_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [RX_W-1:0]   rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    import spi_pkg::*;

    localparam int BW = $clog2(RX_W);
    localparam int WW = $clog2(TX_WAIT_MAX + 1);

    spi_state_e      r_state;
    logic [RX_W-2:0] r_shift;
    logic [BW-1:0]   r_bit_cnt;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_rd_addr_seen;
    logic [RX_W-1:0] r_rx_data;
    logic            r_rx_valid;

    logic [RX_W-1:0] w_frame;
    logic            w_last;
    logic            w_cmd_ok;
    logic            w_load;
    logic            w_ser_done;
    logic            w_miso;

    assign w_frame  = {r_shift, MOSI};
    assign w_last   = (r_bit_cnt == BW'(RX_W - 1));
    assign w_load   = (r_state == WAIT_TX) && !SS_n && tx_valid;
    assign MISO     = w_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

`ifdef SPI_CMD_CHECK_EN
    always_comb begin
        w_cmd_ok = 1'b1;
        case (r_state)
            WRITE:     w_cmd_ok = (w_frame[RX_W-1] == CMD_WR_ADDR[1]);
            READ_ADD:  w_cmd_ok = (w_frame[RX_W-1 -: 2] == CMD_RD_ADDR);
            READ_DATA: w_cmd_ok = (w_frame[RX_W-1 -: 2] == CMD_RD_DATA);
            default:   w_cmd_ok = 1'b1;
        endcase
    end
`else
    assign w_cmd_ok = 1'b1;
`endif

    // SS_n high clears the serializer so MISO drops with the abort
    spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_clr  (SS_n),
        .i_byte (tx_data),
        .o_miso (w_miso),
        .o_done (w_ser_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_rd_addr_seen <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            // abort takes priority over everything, including a completing frame
            if (SS_n && (r_state != IDLE)) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_wait_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: if (!SS_n) r_state <= CHK_CMD;
                    CHK_CMD: begin
                        r_bit_cnt <= '0;
                        if (!MOSI)               r_state <= WRITE;
                        else if (r_rd_addr_seen) r_state <= READ_DATA;
                        else                     r_state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        r_shift   <= w_frame[RX_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            if (!w_cmd_ok) begin
                                r_state <= DONE;
                            end else begin
                                r_rx_data  <= w_frame;
                                r_rx_valid <= 1'b1;
                                if (r_state == WRITE) begin
                                    r_state <= DONE;
                                end else if (r_state == READ_ADD) begin
                                    r_rd_addr_seen <= 1'b1;
                                    r_state        <= DONE;
                                end else begin
                                    r_rd_addr_seen <= 1'b0;
                                    r_wait_cnt     <= '0;
                                    r_state        <= WAIT_TX;
                                end
                            end
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            r_wait_cnt <= '0;
                            r_state    <= SEND;
                        end else if (r_wait_cnt == WW'(TX_WAIT_MAX - 1)) begin
                            r_wait_cnt <= '0;
                            r_state    <= DONE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    SEND:    if (w_ser_done) r_state <= DONE;
                    DONE:    r_state <= DONE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: write/read frames, read timeout, aborts, async reset.
module tb_spi_slave_bridge;
    import spi_pkg::*;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       SS_n     = 1'b1;
    logic       MOSI     = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       MISO;
    logic       rx_valid;
    logic [9:0] rx_data;

    int n_checks = 0;
    int n_err    = 0;
    int n_rxv    = 0;
    int n_miso   = 0;
    int rxv0;
    int miso0;
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    spi_slave_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // counts rx_valid cycles and MISO-high cycles, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid) n_rxv  <= n_rxv + 1;
        if (MISO)     n_miso <= n_miso + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // select, send mode bit, then the first nbits of bits MSB-first
    task automatic frame(input logic mode, input logic [9:0] bits, input int nbits);
        SS_n = 1'b0;
        tick();
        MOSI = mode;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = bits[9-i];
            tick();
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_miso",   MISO, 0);
        chk("rst_rxv",    rx_valid, 0);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_state",  dut.r_state, IDLE);
        rst = 1'b0;
        tick();

        // write address
        rxv0 = n_rxv;
        frame(1'b0, 10'h02A, 10);
        chk("wa_rxv",   rx_valid, 1);
        chk("wa_data",  rx_data, 10'h02A);
        chk("wa_state", dut.r_state, DONE);
        tick();
        chk("wa_rxv_off", rx_valid, 0);
        SS_n = 1'b1; tick();
        chk("wa_idle",   dut.r_state, IDLE);
        chk("wa_pulses", n_rxv - rxv0, 1);

        // write data, DONE holds while selected
        rxv0 = n_rxv;
        frame(1'b0, 10'h1A5, 10);
        chk("wd_rxv",  rx_valid, 1);
        chk("wd_data", rx_data, 10'h1A5);
        repeat (3) tick();
        chk("wd_hold",   dut.r_state, DONE);
        chk("wd_pulses", n_rxv - rxv0, 1);
        SS_n = 1'b1; tick();
        chk("wd_idle", dut.r_state, IDLE);

        // read address
        frame(1'b1, 10'h203, 10);
        chk("ra_rxv",   rx_valid, 1);
        chk("ra_data",  rx_data, 10'h203);
        chk("ra_seen",  dut.r_rd_addr_seen, 1);
        chk("ra_state", dut.r_state, DONE);
        chk("wr_miso_quiet", n_miso, 0);
        SS_n = 1'b1; tick();

        // read data, tx_valid two cycles later, byte C3 on MISO
        frame(1'b1, 10'h3F0, 10);
        chk("rd_rxv",   rx_valid, 1);
        chk("rd_data",  rx_data, 10'h3F0);
        chk("rd_wait",  dut.r_state, WAIT_TX);
        chk("rd_seen0", dut.r_rd_addr_seen, 0);
        repeat (2) tick();
        chk("rd_miso_wait", MISO, 0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        exp_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("rd_miso_b%0d", i), MISO, exp_byte[i]);
            tick();
        end
        chk("rd_miso_end", MISO, 0);
        chk("rd_done",     dut.r_state, DONE);
        SS_n = 1'b1; tick();

        // read timeout
        frame(1'b1, 10'h200, 10);
        SS_n = 1'b1; tick();
        frame(1'b1, 10'h3AA, 10);
        chk("to_wait", dut.r_state, WAIT_TX);
        miso0 = n_miso;
        repeat (14) tick();
        chk("to_wait14", dut.r_state, WAIT_TX);
        tick();
        chk("to_done15", dut.r_state, DONE);
        repeat (4) tick();
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        chk("to_ignore_tx", dut.r_state, DONE);
        chk("to_miso_now",  MISO, 0);
        chk("to_miso_cnt",  n_miso - miso0, 0);
        SS_n = 1'b1; tick();
        frame(1'b1, 10'h000, 0);
        chk("to_next_rdadd", dut.r_state, READ_ADD);
        SS_n = 1'b1; tick();
        chk("to_abort_idle", dut.r_state, IDLE);

        // aborts
        rxv0 = n_rxv;
        frame(1'b0, 10'h155, 6);
        SS_n = 1'b1; tick();
        chk("ab6_idle", dut.r_state, IDLE);
        frame(1'b0, 10'h155, 9);
        MOSI = 1'b1; SS_n = 1'b1;
        tick();
        chk("ab10_rxv",  rx_valid, 0);
        chk("ab10_idle", dut.r_state, IDLE);
        tick();
        chk("ab_pulses", n_rxv - rxv0, 0);

        // an aborted read-data frame keeps rd_addr_seen
        frame(1'b1, 10'h201, 10);
        SS_n = 1'b1; tick();
        frame(1'b1, 10'h3C3, 5);
        SS_n = 1'b1; tick();
        chk("ab_seen_kept", dut.r_rd_addr_seen, 1);

        // write-mode frame carrying read command bits
        frame(1'b0, 10'h3FF, 10);
`ifdef SPI_CMD_CHECK_EN
        chk("cc_rxv", rx_valid, 0);
`else
        chk("cc_rxv",  rx_valid, 1);
        chk("cc_data", rx_data, 10'h3FF);
`endif
        chk("cc_done", dut.r_state, DONE);
        SS_n = 1'b1; tick();

        // async reset during the third MISO bit
        frame(1'b1, 10'h3C3, 10);
        chk("rs_wait", dut.r_state, WAIT_TX);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        repeat (2) tick();
        chk("rs_bit3",  MISO, 1);
        chk("rs_send",  dut.r_state, SEND);
        rst = 1'b1;
        #1;
        chk("rs_miso",   MISO, 0);
        chk("rs_rxv",    rx_valid, 0);
        chk("rs_rxdata", rx_data, 0);
        chk("rs_state",  dut.r_state, IDLE);
        chk("rs_seen",   dut.r_rd_addr_seen, 0);
        SS_n = 1'b1;
        #2;
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
